// File: rtl/quad_decoder.sv
// quad_decoder: synchronised quadrature decoder with up/down position count and illegal-step detection
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit WRAP        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             up,
    output logic             step,
    output logic             err,
    output logic             err_flag
);
    localparam logic [1:0] S_INIT = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2;
    logic [SYNC_STAGES-1:0] r_a_sync, r_b_sync;
    logic [1:0] r_state, r_wait, r_prev;
    logic [1:0] w_s, w_pos, w_prev_pos, w_diff;
    logic w_run, w_inc, w_dec, w_bad;
    logic [WIDTH-1:0] w_next;

    assign w_s = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};
    // Gray phase to quadrant index (00,10,11,01 -> 0,1,2,3) so a step is a +/-1 difference
    assign w_pos = {w_s[0], ^w_s};
    assign w_prev_pos = {r_prev[0], ^r_prev};
    assign w_diff = w_pos - w_prev_pos;
    assign w_run = r_state == S_RUN;
    assign w_inc = w_run && w_diff == 2'd1;
    assign w_dec = w_run && w_diff == 2'd3;
    assign w_bad = w_run && w_diff == 2'd2;

    // Next position: wrap modulo 2^WIDTH or hold at the range limits
    always_comb begin
        w_next = count;
        if (w_inc) w_next = (WRAP || count != '1) ? count + 1'b1 : count;
        else if (w_dec) w_next = (WRAP || count != '0) ? count - 1'b1 : count;
    end

    // Input synchroniser chains for the asynchronous phases
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sync <= '0;
            r_b_sync <= '0;
        end else begin
            r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], a_in};
            r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], b_in};
        end
    end

    // Sequencer: flush the synchroniser, load prev once, then track prev every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_wait <= '0;
            r_prev <= '0;
        end else if (r_state == S_INIT) begin
            r_wait <= r_wait + 1'b1;
            if (r_wait == 2'(SYNC_STAGES - 1)) r_state <= S_LOAD;
        end else begin
            r_prev <= w_s;
            r_state <= S_RUN;
        end
    end

    // Registered outputs; clr wins over a coincident count or error update
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            up <= 1'b1;
            step <= 1'b0;
            err <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            count <= clr ? '0 : w_next;
            step <= w_inc || w_dec;
            err <= w_bad;
            err_flag <= !clr && (err_flag || w_bad);
            if (w_inc || w_dec) up <= w_inc;
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven and randomized checks of quad_decoder against a sample-history model
module tb_quad_decoder;
    localparam int SYNC = 2;

    typedef struct {
        logic       a, b;
        int         n, step_at, err_at, clr_at, rst_at;
        logic [7:0] cw, cs;
        logic       up, flag;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, a_in = 1'b0, b_in = 1'b0, clr = 1'b0;
    logic [7:0] cnt_w, cnt_s;
    logic up_w, step_w, err_w, flag_w, up_s, step_s, err_s, flag_s;

    int checks = 0, errors = 0;
    int m_cw, m_cs;
    logic m_up, m_step, m_err, m_flag;
    logic [1:0] hist[$];
    logic [1:0] ring[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    vec_t tbl[$];

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(SYNC), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr),
        .count(cnt_w), .up(up_w), .step(step_w), .err(err_w), .err_flag(flag_w)
    );

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(SYNC), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr),
        .count(cnt_s), .up(up_s), .step(step_s), .err(err_s), .err_flag(flag_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ring_idx(input logic [1:0] v);
        for (int i = 0; i < 4; i++) if (ring[i] == v) return i;
        return 0;
    endfunction

    function automatic vec_t v(input logic a, input logic b, input int n, input int step_at, input int err_at,
                               input int clr_at, input int rst_at, input int cw, input int cs,
                               input logic up, input logic flag);
        vec_t r;
        r.a = a; r.b = b; r.n = n; r.step_at = step_at; r.err_at = err_at;
        r.clr_at = clr_at; r.rst_at = rst_at; r.cw = 8'(cw); r.cs = 8'(cs); r.up = up; r.flag = flag;
        return r;
    endfunction

    // One clock edge: advance the model from the levels present at the edge, then compare both DUTs
    task automatic tick();
        int d;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_cw = 0; m_cs = 0; m_up = 1'b1; m_step = 1'b0; m_err = 1'b0; m_flag = 1'b0;
        end else begin
            hist.push_back({a_in, b_in});
            if (hist.size() > SYNC + 2) void'(hist.pop_front());
            m_step = 1'b0; m_err = 1'b0;
            if (hist.size() == SYNC + 2) begin
                d = (ring_idx(hist[1]) - ring_idx(hist[0]) + 4) % 4;
                if (d == 1) begin
                    m_step = 1'b1; m_up = 1'b1;
                    m_cw = (m_cw + 1) % 256;
                    m_cs = (m_cs < 255) ? m_cs + 1 : 255;
                end else if (d == 3) begin
                    m_step = 1'b1; m_up = 1'b0;
                    m_cw = (m_cw + 255) % 256;
                    m_cs = (m_cs > 0) ? m_cs - 1 : 0;
                end else if (d == 2) begin
                    m_err = 1'b1; m_flag = 1'b1;
                end
            end
            if (clr) begin
                m_cw = 0; m_cs = 0; m_flag = 1'b0;
            end
        end
        #1;
        check("cycle", int'({cnt_w, cnt_s, up_w, step_w, err_w, flag_w, up_s, step_s, err_s, flag_s}),
              int'({8'(m_cw), 8'(m_cs), m_up, m_step, m_err, m_flag, m_up, m_step, m_err, m_flag}));
    endtask

    initial begin
        int first_step, first_err, nstep, nerr, p, r, hold;
        // Directed phase sequence: forward, reverse through zero, illegal jump, clr, mid-run reset
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   1, 1, 1'b1, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 0, 0,   2, 2, 1'b1, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0,   3, 3, 1'b1, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   4, 4, 1'b1, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0,   3, 3, 1'b0, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 0, 0,   2, 2, 1'b0, 1'b0));
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   1, 1, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   0, 0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0, 255, 0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   0, 1, 1'b1, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 4, 0, 3, 0, 0,   0, 1, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0,   1, 2, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   2, 3, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   3, 4, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 0, 0,   4, 5, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0,   5, 6, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   6, 7, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   7, 8, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 3, 0,   0, 0, 1'b1, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4, 0, 3, 0, 0,   0, 0, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   1, 1, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 0, 0,   2, 2, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 4, 3, 0, 0, 0,   3, 3, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4, 3, 0, 0, 0,   4, 4, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 4, 3, 0, 0, 0,   5, 5, 1'b1, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, 6, 0, 0, 0, 1,   0, 0, 1'b1, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, 4, 3, 0, 0, 0,   1, 1, 1'b1, 1'b0));

        // Reset with both phases high, then quiet hold
        a_in = 1'b1; b_in = 1'b1; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) begin
            tick();
            check("quiet_after_reset", int'({step_w, err_w, up_w, flag_w, cnt_w}), int'({4'b0010, 8'd0}));
        end

        // Re-reset at (0,0) to start the directed sequence from a known phase
        a_in = 1'b0; b_in = 1'b0; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();

        foreach (tbl[i]) begin
            first_step = 0; first_err = 0; nstep = 0; nerr = 0;
            a_in = tbl[i].a; b_in = tbl[i].b;
            for (int c = 1; c <= tbl[i].n; c++) begin
                clr = (c == tbl[i].clr_at);
                rst = (c == tbl[i].rst_at);
                tick();
                clr = 1'b0; rst = 1'b0;
                if (step_w) begin nstep++; if (first_step == 0) first_step = c; end
                if (err_w) begin nerr++; if (first_err == 0) first_err = c; end
            end
            check($sformatf("row%0d step_cycle", i), first_step, tbl[i].step_at);
            check($sformatf("row%0d step_count", i), nstep, (tbl[i].step_at != 0) ? 1 : 0);
            check($sformatf("row%0d err_cycle", i), first_err, tbl[i].err_at);
            check($sformatf("row%0d err_count", i), nerr, (tbl[i].err_at != 0) ? 1 : 0);
            check($sformatf("row%0d count_wrap", i), int'(cnt_w), int'(tbl[i].cw));
            check($sformatf("row%0d count_sat", i), int'(cnt_s), int'(tbl[i].cs));
            check($sformatf("row%0d up", i), int'(up_w), int'(tbl[i].up));
            check($sformatf("row%0d err_flag", i), int'(flag_w), int'(tbl[i].flag));
        end

        // Randomized walk: forward-biased to hit the top limit, then reverse-biased back to zero
        p = ring_idx({a_in, b_in});
        for (int ph = 0; ph < 2; ph++) begin
            repeat (700) begin
                r = $urandom_range(0, 99);
                if (r < 6) p = (p + 2) % 4;
                else if (r < 76) p = (ph == 0) ? (p + 1) % 4 : (p + 3) % 4;
                else if (r < 90) p = (ph == 0) ? (p + 3) % 4 : (p + 1) % 4;
                {a_in, b_in} = ring[p];
                hold = $urandom_range(1, 5);
                repeat (hold) begin
                    clr = ($urandom_range(0, 999) == 0);
                    rst = ($urandom_range(0, 1499) == 0);
                    tick();
                    clr = 1'b0; rst = 1'b0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
